alu_arbiter: RTL and testbench

Shares the core's single combinational ALU between two requesters: port 0 (execute stage) and port 1 (secondary unit, e.g. address generation or debug). Each port uses a valid/ready handshake, and the block arbitrates round-robin. The ALU result is captured in a one-entry output register with its own valid/ready handshake. The block sits between the requesters and the ALU instance, which it owns.

---
 rtl/alu_arbiter_pkg.sv | 40 ++++
 rtl/alu_arbiter_alu.sv | 57 +++++
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared types for the ALU arbiter slice: the ALU funct field types, the
// per-port request bundle, the port count and the output-register FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    typedef logic [2:0] Funct3_t;
    typedef logic [6:0] Funct7_t;

    localparam int ALU_ARB_PORTS = 2;

    // funct3 encodings understood by the ALU
    localparam Funct3_t F3_ADD  = 3'b000;
    localparam Funct3_t F3_SLL  = 3'b001;
    localparam Funct3_t F3_SLT  = 3'b010;
    localparam Funct3_t F3_SLTU = 3'b011;
    localparam Funct3_t F3_XOR  = 3'b100;
    localparam Funct3_t F3_SR   = 3'b101;
    localparam Funct3_t F3_OR   = 3'b110;
    localparam Funct3_t F3_AND  = 3'b111;

    // One requester's complete ALU operation
    typedef struct packed {
        Funct3_t     funct3;
        Funct7_t     funct7;
        logic        opImm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] immediateI;
    } AluReq_t;

    // Output result register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu
// The core's combinational integer ALU (RV32I register/immediate ops).
// Ports:
//   req    in  AluReq_t   operation and operands
//   result out [31:0]     32-bit wrap-around result
// The second operand is immediateI when opImm=1, otherwise rs2.
// -----------------------------------------------------------------------------
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  AluReq_t     req,
    output logic [31:0] result
);

    logic [31:0] operand_b_s;
    logic [4:0]  shamt_s;
    logic        alt_s;
    logic        is_sub_s;
    logic        unused_funct7_s;

    assign operand_b_s     = req.opImm ? req.immediateI : req.rs2;
    assign shamt_s         = operand_b_s[4:0];
    assign alt_s           = req.funct7[5];
    // An immediate add never subtracts, whatever funct7 happens to carry.
    assign is_sub_s        = alt_s & ~req.opImm;
    assign unused_funct7_s = ^{req.funct7[6], req.funct7[4:0]};

    // Operation decode and datapath
    always_comb begin
        result = 32'h0;
        case (req.funct3)
            F3_ADD: begin
                if (is_sub_s) begin
                    result = req.rs1 - operand_b_s;
                end else begin
                    result = req.rs1 + operand_b_s;
                end
            end
            F3_SLL:  result = req.rs1 << shamt_s;
            F3_SLT:  result = {31'h0, ($signed(req.rs1) < $signed(operand_b_s))};
            F3_SLTU: result = {31'h0, (req.rs1 < operand_b_s)};
            F3_XOR:  result = req.rs1 ^ operand_b_s;
            F3_SR: begin
                if (alt_s) begin
                    result = $unsigned($signed(req.rs1) >>> shamt_s);
                end else begin
                    result = req.rs1 >> shamt_s;
                end
            end
            F3_OR:   result = req.rs1 | operand_b_s;
            F3_AND:  result = req.rs1 & operand_b_s;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters with round-robin
// arbitration and a one-entry registered result with valid/ready handshake.
// Ports:
//   clock, reset                    clock, synchronous active-high reset
//   reqValid / reqReady [1:0]       per-port request handshake
//   reqFunct3, reqFunct7, reqOpImm  per-port operation select
//   reqRs1, reqRs2, reqImmediateI   per-port operands
//   rspValid / rspReady             result handshake
//   rspData, rspPort                registered result and issuing port
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = ALU_ARB_PORTS
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_PORTS-1:0]       reqValid,
    output logic [NUM_PORTS-1:0]       reqReady,
    input  Funct3_t [NUM_PORTS-1:0]    reqFunct3,
    input  Funct7_t [NUM_PORTS-1:0]    reqFunct7,
    input  logic [NUM_PORTS-1:0]       reqOpImm,
    input  logic [NUM_PORTS-1:0][31:0] reqRs1,
    input  logic [NUM_PORTS-1:0][31:0] reqRs2,
    input  logic [NUM_PORTS-1:0][31:0] reqImmediateI,
    output logic                       rspValid,
    input  logic                       rspReady,
    output logic [31:0]                rspData,
    output logic                       rspPort
);

    rsp_state_t             state_r;
    rsp_state_t             state_nxt_s;
    logic                   prio_r;
    logic [31:0]            rsp_data_r;
    logic                   rsp_port_r;

    AluReq_t                req_s [NUM_PORTS];
    AluReq_t                sel_req_s;
    logic [NUM_PORTS-1:0]   grant_s;
    logic                   grant_port_s;
    logic                   grant_valid_s;
    logic                   can_accept_s;
    logic                   accept_s;
    logic [31:0]            alu_result_s;

    // Bundle each port's request fields
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_s[p].funct3     = reqFunct3[p];
            req_s[p].funct7     = reqFunct7[p];
            req_s[p].opImm      = reqOpImm[p];
            req_s[p].rs1        = reqRs1[p];
            req_s[p].rs2        = reqRs2[p];
            req_s[p].immediateI = reqImmediateI[p];
        end
    end

    // Round-robin grant: a lone requester always wins, prio breaks ties
    always_comb begin
        grant_s       = 2'b00;
        grant_port_s  = 1'b0;
        grant_valid_s = 1'b0;
        case (reqValid)
            2'b01: begin
                grant_s       = 2'b01;
                grant_port_s  = 1'b0;
                grant_valid_s = 1'b1;
            end
            2'b10: begin
                grant_s       = 2'b10;
                grant_port_s  = 1'b1;
                grant_valid_s = 1'b1;
            end
            2'b11: begin
                grant_port_s  = prio_r;
                grant_valid_s = 1'b1;
                if (prio_r) begin
                    grant_s = 2'b10;
                end else begin
                    grant_s = 2'b01;
                end
            end
            default: begin
                grant_s       = 2'b00;
                grant_port_s  = 1'b0;
                grant_valid_s = 1'b0;
            end
        endcase
    end

    // A slot is free when empty or when the held result leaves this edge.
    assign can_accept_s = (state_r == ST_EMPTY) | rspReady;
    // Nothing is accepted while reset is asserted.
    assign accept_s     = grant_valid_s & can_accept_s & ~reset;

    // Request-side ready and the grant mux into the ALU
    always_comb begin
        if (accept_s) begin
            reqReady = grant_s;
        end else begin
            reqReady = 2'b00;
        end
        if (grant_port_s) begin
            sel_req_s = req_s[1];
        end else begin
            sel_req_s = req_s[0];
        end
    end

    alu_arbiter_alu u_alu (
        .req    (sel_req_s),
        .result (alu_result_s)
    );

    // Output register occupancy next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else if (rspReady) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // State, priority pointer and result register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_EMPTY;
            prio_r     <= 1'b0;
            rsp_data_r <= 32'h0;
            rsp_port_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                rsp_data_r <= alu_result_s;
                rsp_port_r <= grant_port_s;
                prio_r     <= ~grant_port_s;
            end else begin
                rsp_data_r <= rsp_data_r;
                rsp_port_r <= rsp_port_r;
                prio_r     <= prio_r;
            end
        end
    end

    assign rspValid = (state_r == ST_FULL);
    assign rspData  = rsp_data_r;
    assign rspPort  = rsp_port_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed, table-driven bench for alu_arbiter. Each table row is one clock:
// inputs applied on the falling edge, reqReady checked before the rising edge,
// result outputs checked just after it. A hand-written reset sequence follows.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic                clock;
    logic                reset;
    logic [1:0]          reqValid;
    logic [1:0]          reqReady;
    Funct3_t [1:0]       reqFunct3;
    Funct7_t [1:0]       reqFunct7;
    logic [1:0]          reqOpImm;
    logic [1:0][31:0]    reqRs1;
    logic [1:0][31:0]    reqRs2;
    logic [1:0][31:0]    reqImmediateI;
    logic                rspValid;
    logic                rspReady;
    logic [31:0]         rspData;
    logic                rspPort;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic        rr;
        AluReq_t     r0;
        AluReq_t     r1;
        logic [1:0]  exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_port;
    } vec_t;

    vec_t vecs[$];

    alu_arbiter #(.NUM_PORTS(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .reqValid      (reqValid),
        .reqReady      (reqReady),
        .reqFunct3     (reqFunct3),
        .reqFunct7     (reqFunct7),
        .reqOpImm      (reqOpImm),
        .reqRs1        (reqRs1),
        .reqRs2        (reqRs2),
        .reqImmediateI (reqImmediateI),
        .rspValid      (rspValid),
        .rspReady      (rspReady),
        .rspData       (rspData),
        .rspPort       (rspPort)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic AluReq_t rq(input logic [2:0] f3, input logic [6:0] f7,
                                   input logic opimm, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] imm);
        AluReq_t r;
        r.funct3     = f3;
        r.funct7     = f7;
        r.opImm      = opimm;
        r.rs1        = a;
        r.rs2        = b;
        r.immediateI = imm;
        return r;
    endfunction

    task automatic add_vec(input logic rst, input logic [1:0] v, input logic rr,
                           input AluReq_t r0, input AluReq_t r1,
                           input logic [1:0] er, input logic ev,
                           input logic [31:0] ed, input logic ep);
        vec_t x;
        x.rst = rst; x.v = v; x.rr = rr; x.r0 = r0; x.r1 = r1;
        x.exp_ready = er; x.exp_valid = ev; x.exp_data = ed; x.exp_port = ep;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] v, input logic rr,
                         input AluReq_t r0, input AluReq_t r1);
        reset    = rst;
        reqValid = v;
        rspReady = rr;
        reqFunct3[0] = r0.funct3;  reqFunct3[1] = r1.funct3;
        reqFunct7[0] = r0.funct7;  reqFunct7[1] = r1.funct7;
        reqOpImm[0]  = r0.opImm;   reqOpImm[1]  = r1.opImm;
        reqRs1[0]    = r0.rs1;     reqRs1[1]    = r1.rs1;
        reqRs2[0]    = r0.rs2;     reqRs2[1]    = r1.rs2;
        reqImmediateI[0] = r0.immediateI;
        reqImmediateI[1] = r1.immediateI;
    endtask

    // One clock: drive on falling edge, check ready, then result after rising edge
    task automatic step(input string tag, input logic rst, input logic [1:0] v,
                        input logic rr, input AluReq_t r0, input AluReq_t r1,
                        input logic [1:0] er, input logic ev,
                        input logic [31:0] ed, input logic ep);
        @(negedge clock);
        drive(rst, v, rr, r0, r1);
        #1;
        chk({tag, " reqReady"}, {30'h0, reqReady}, {30'h0, er});
        @(posedge clock);
        #1;
        chk({tag, " rspValid"}, {31'h0, rspValid}, {31'h0, ev});
        chk({tag, " rspData"}, rspData, ed);
        chk({tag, " rspPort"}, {31'h0, rspPort}, {31'h0, ep});
    endtask

    initial begin
        AluReq_t nop, add57, sub, srai, slt_r, sltu_r, sll_r;
        nop    = '0;
        add57  = rq(3'b000, 7'b0000000, 1'b0, 32'd5, 32'd7, 32'd0);
        sub    = rq(3'b000, 7'b0100000, 1'b0, 32'd10, 32'd3, 32'd0);
        srai   = rq(3'b101, 7'b0100000, 1'b1, 32'h8000_0000, 32'd0, 32'd4);
        slt_r  = rq(3'b010, 7'b0000000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        sltu_r = rq(3'b011, 7'b0000000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        sll_r  = rq(3'b001, 7'b0000000, 1'b0, 32'd1, 32'd33, 32'd0);

        drive(1'b1, 2'b00, 1'b0, nop, nop);

        //      rst   valid  rr    port0   port1   ready  vld   data            port
        // reset with requests pending: nothing accepted, outputs cleared
        add_vec(1'b1, 2'b11, 1'b1, sub,    srai,   2'b00, 1'b0, 32'h0,          1'b0);
        // contention, rspReady=1: grants 0,1,0,1 back-to-back
        add_vec(1'b0, 2'b11, 1'b1, sub,    srai,   2'b01, 1'b1, 32'd7,          1'b0);
        add_vec(1'b0, 2'b11, 1'b1, sub,    srai,   2'b10, 1'b1, 32'hF800_0000,  1'b1);
        add_vec(1'b0, 2'b11, 1'b1, sub,    srai,   2'b01, 1'b1, 32'd7,          1'b0);
        add_vec(1'b0, 2'b11, 1'b1, sub,    srai,   2'b10, 1'b1, 32'hF800_0000,  1'b1);
        // single port 0 add -> 12, prio moves to 1
        add_vec(1'b0, 2'b01, 1'b1, add57,  nop,    2'b01, 1'b1, 32'd12,         1'b0);
        // backpressure: 3 stalled cycles, result held, no ready
        add_vec(1'b0, 2'b11, 1'b0, add57,  srai,   2'b00, 1'b1, 32'd12,         1'b0);
        add_vec(1'b0, 2'b11, 1'b0, add57,  srai,   2'b00, 1'b1, 32'd12,         1'b0);
        add_vec(1'b0, 2'b11, 1'b0, add57,  srai,   2'b00, 1'b1, 32'd12,         1'b0);
        // release: accept in same cycle, prio still 1 so port 1 wins
        add_vec(1'b0, 2'b11, 1'b1, add57,  srai,   2'b10, 1'b1, 32'hF800_0000,  1'b1);
        // drain: empty, data/port held
        add_vec(1'b0, 2'b00, 1'b1, nop,    nop,    2'b00, 1'b0, 32'hF800_0000,  1'b1);
        // compare ops on port 1 alone
        add_vec(1'b0, 2'b10, 1'b1, nop,    slt_r,  2'b10, 1'b1, 32'd1,          1'b1);
        add_vec(1'b0, 2'b10, 1'b1, nop,    sltu_r, 2'b10, 1'b1, 32'd0,          1'b1);
        add_vec(1'b0, 2'b10, 1'b1, nop,    sll_r,  2'b10, 1'b1, 32'd2,          1'b1);
        // idle fairness: after port 1's grants, both valid -> port 0
        add_vec(1'b0, 2'b11, 1'b1, add57,  slt_r,  2'b01, 1'b1, 32'd12,         1'b0);
        add_vec(1'b0, 2'b00, 1'b0, nop,    nop,    2'b00, 1'b1, 32'd12,         1'b0);
        add_vec(1'b0, 2'b00, 1'b1, nop,    nop,    2'b00, 1'b0, 32'd12,         1'b0);
        // remaining ALU ops on port 0
        add_vec(1'b0, 2'b01, 1'b1, rq(3'b100, 7'h00, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0),
                nop, 2'b01, 1'b1, 32'hFF00_FF00, 1'b0);
        add_vec(1'b0, 2'b01, 1'b1, rq(3'b110, 7'h00, 1'b1, 32'h00FF_0000, 32'hFFFF_FFFF, 32'hF),
                nop, 2'b01, 1'b1, 32'h00FF_000F, 1'b0);
        add_vec(1'b0, 2'b01, 1'b1, rq(3'b111, 7'h00, 1'b0, 32'h1234_5678, 32'h0000_FFFF, 32'h0),
                nop, 2'b01, 1'b1, 32'h0000_5678, 1'b0);
        add_vec(1'b0, 2'b01, 1'b1, rq(3'b101, 7'h00, 1'b0, 32'h8000_0000, 32'd4, 32'h0),
                nop, 2'b01, 1'b1, 32'h0800_0000, 1'b0);
        // addi with funct7[5]=1 still adds
        add_vec(1'b0, 2'b01, 1'b1, rq(3'b000, 7'b0100000, 1'b1, 32'd10, 32'd99, 32'd3),
                nop, 2'b01, 1'b1, 32'd13, 1'b0);
        // 32-bit wrap-around
        add_vec(1'b0, 2'b01, 1'b1, rq(3'b000, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0),
                nop, 2'b01, 1'b1, 32'd1, 1'b0);
        add_vec(1'b0, 2'b01, 1'b1, rq(3'b011, 7'h00, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h0),
                nop, 2'b01, 1'b1, 32'd1, 1'b0);
        add_vec(1'b0, 2'b01, 1'b1, rq(3'b010, 7'h00, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h0),
                nop, 2'b01, 1'b1, 32'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].v, vecs[i].rr,
                 vecs[i].r0, vecs[i].r1, vecs[i].exp_ready, vecs[i].exp_valid,
                 vecs[i].exp_data, vecs[i].exp_port);
        end

        // Reset mid-operation: accept on port 0 (prio -> 1), then reset
        step("rst_accept", 1'b0, 2'b01, 1'b1, add57, nop, 2'b01, 1'b1, 32'd12, 1'b0);
        step("rst_assert", 1'b1, 2'b11, 1'b0, sub, srai, 2'b00, 1'b0, 32'h0, 1'b0);
        // prio back to 0: port 0 first despite port 0 being last granted
        step("rst_after0", 1'b0, 2'b11, 1'b1, sub, srai, 2'b01, 1'b1, 32'd7, 1'b0);
        step("rst_after1", 1'b0, 2'b11, 1'b1, sub, srai, 2'b10, 1'b1, 32'hF800_0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
